// File: rtl/accum_pkg.sv
// Shared FSM state type and default widths for the accumulator frame controller.
package accum_pkg;

    localparam int DEF_DIN_WIDTH  = 32;
    localparam int DEF_DOUT_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUT
    } state_t;

endpackage

// File: rtl/accum_frame_ctrl_if.sv
// Bus bundle between the frame controller (slave side) and its environment (master side):
// frame start, upstream sample stream, external accumulator and downstream result.
interface accum_frame_ctrl_if
    import accum_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

    logic                  start_i;
    logic [LEN_WIDTH-1:0]  frame_len_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DIN_WIDTH-1:0]  s_data_i;
    logic                  acc_clear_o;
    logic                  acc_enable_o;
    logic [DIN_WIDTH-1:0]  acc_data_o;
    logic [DOUT_WIDTH-1:0] acc_sum_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DOUT_WIDTH-1:0] m_sum_o;
    logic                  m_ovf_o;
    logic                  busy_o;

    modport slave (
        input  start_i, frame_len_i, s_valid_i, s_data_i, acc_sum_i, m_ready_i,
        output s_ready_o, acc_clear_o, acc_enable_o, acc_data_o,
        output m_valid_o, m_sum_o, m_ovf_o, busy_o
    );

    modport master (
        output start_i, frame_len_i, s_valid_i, s_data_i, acc_sum_i, m_ready_i,
        input  s_ready_o, acc_clear_o, acc_enable_o, acc_data_o,
        input  m_valid_o, m_sum_o, m_ovf_o, busy_o
    );

endinterface

// File: rtl/accum_ovf_chk.sv
// Sticky signed-overflow detector for one frame; only present when ACCUM_FRAME_CTRL_OVF_EN is defined.
`ifdef ACCUM_FRAME_CTRL_OVF_EN
module accum_ovf_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic handshake,
    input  logic data_sign,
    input  logic sum_sign,
    output logic ovf
);

    logic pend_reg;
    logic sign_reg;
    logic ovf_reg;

    // A same-sign addition is remembered for one cycle, then judged on the registered sum.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pend_reg <= 1'b0;
            sign_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            pend_reg <= handshake && (data_sign == sum_sign);
            sign_reg <= sum_sign;
            if (pend_reg && (sum_sign != sign_reg)) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign ovf = ovf_reg;

endmodule
`endif

// File: rtl/accum_frame_ctrl.sv
// Frame controller steering an external accumulator: clear, accumulate N samples, capture, present.
// Define ACCUM_FRAME_CTRL_OVF_EN to build the sticky signed-overflow flag; otherwise m_ovf_o is 0.
module accum_frame_ctrl
    import accum_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    accum_frame_ctrl_if.slave bus
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state_reg;
    state_t                state_next;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  cnt_reg;
    logic [DOUT_WIDTH-1:0] sum_reg;

    logic start_ok;
    logic in_accum;
    logic handshake;
    logic last_sample;
    logic acc_clear;
    logic m_valid;
    logic busy;
    logic ovf;

    assign start_ok    = bus.start_i && (bus.frame_len_i != '0);
    assign in_accum    = rst_n && (state_reg == ST_ACCUM);
    assign handshake   = in_accum && bus.s_valid_i;
    assign last_sample = handshake && ((cnt_reg + LEN_ONE) == len_reg);

    always_comb begin
        state_next = state_reg;
        acc_clear  = !rst_n;
        m_valid    = 1'b0;
        busy       = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_next = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    acc_clear  = 1'b1;
                    busy       = 1'b1;
                    state_next = ST_ACCUM;
                end
                ST_ACCUM: begin
                    busy = 1'b1;
                    if (last_sample) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    busy       = 1'b1;
                    state_next = ST_OUT;
                end
                ST_OUT: begin
                    busy    = 1'b1;
                    m_valid = 1'b1;
                    if (bus.m_ready_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start_ok) begin
                len_reg <= bus.frame_len_i;
            end
            if (state_reg == ST_CLEAR) begin
                cnt_reg <= '0;
            end else if (handshake) begin
                cnt_reg <= cnt_reg + LEN_ONE;
            end
            // The accumulator is registered, so in DRAIN it already holds the last sample.
            if (state_reg == ST_DRAIN) begin
                sum_reg <= bus.acc_sum_i;
            end
        end
    end

`ifdef ACCUM_FRAME_CTRL_OVF_EN
    accum_ovf_chk u_ovf_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (rst_n && (state_reg == ST_CLEAR)),
        .handshake (handshake),
        .data_sign (bus.s_data_i[DIN_WIDTH-1]),
        .sum_sign  (bus.acc_sum_i[DOUT_WIDTH-1]),
        .ovf       (ovf)
    );
`else
    assign ovf = 1'b0;
`endif

    assign bus.s_ready_o    = in_accum;
    assign bus.acc_clear_o  = acc_clear;
    assign bus.acc_enable_o = handshake;
    assign bus.acc_data_o   = handshake ? bus.s_data_i : '0;
    assign bus.m_valid_o    = m_valid;
    assign bus.m_sum_o      = sum_reg;
    assign bus.m_ovf_o      = ovf;
    assign bus.busy_o       = busy;

endmodule

// File: doc/accum_frame_ctrl.md
ACCUM_FRAME_CTRL -- requirements
Module: accum_frame_ctrl

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32, sample width (signed).
REQ-002 SHALL have parameter DOUT_WIDTH, default 32, accumulator width; DOUT_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, frame-length counter width.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start_i  in  1  frame start request.
REQ-007 SHALL have port frame_len_i  in  LEN_WIDTH  samples per frame, sampled on accepted start.
REQ-008 SHALL have port s_valid_i  in  1  upstream sample valid.
REQ-009 SHALL have port s_ready_o  out  1  upstream sample ready.
REQ-010 SHALL have port s_data_i  in  DIN_WIDTH  signed sample.
REQ-011 SHALL have port acc_clear_o  out  1  drives accumulator clear.
REQ-012 SHALL have port acc_enable_o  out  1  drives accumulator enable.
REQ-013 SHALL have port acc_data_o  out  DIN_WIDTH  drives accumulator data.
REQ-014 SHALL have port acc_sum_i  in  DOUT_WIDTH  registered accumulator result.
REQ-015 SHALL have port m_valid_o  out  1  frame result valid.
REQ-016 SHALL have port m_ready_i  in  1  downstream ready.
REQ-017 SHALL have port m_sum_o  out  DOUT_WIDTH  frame sum, signed.
REQ-018 SHALL have port m_ovf_o  out  1  sticky signed overflow flag for the frame.
REQ-019 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> CLEAR -> ACCUM -> DRAIN -> OUT -> IDLE.
REQ-021 IDLE: start_i=1 with frame_len_i!=0 SHALL latch length, go CLEAR; start_i with length 0, or start_i in any other state, SHALL be ignored.
REQ-022 CLEAR: acc_clear_o=1 for exactly one cycle, s_ready_o=0; then ACCUM.
REQ-023 ACCUM: s_ready_o=1; handshake = s_valid_i & s_ready_o; acc_enable_o = handshake combinationally; acc_data_o = s_data_i on handshake, else 0.
REQ-024 Sample counter SHALL increment per handshake only; handshake on sample number len SHALL transition to DRAIN; gaps in s_valid_i SHALL not advance state.
REQ-025 DRAIN (one cycle, s_ready_o=0): m_sum_o SHALL capture acc_sum_i (value already includes last sample); then OUT.
REQ-026 OUT: m_valid_o=1, m_sum_o/m_ovf_o stable until m_valid_o & m_ready_i; that cycle SHALL return to IDLE; start_i same cycle ignored.
REQ-027 Latency: continuous valid, m_ready_i=1, frame of N samples SHALL present m_valid_o N+3 cycles after accepted start.
REQ-028 Overflow: on each handshake, same sign of acc_sum_i and sign-extended s_data_i with opposite sign of acc_sum_i next cycle SHALL set m_ovf_o; cleared in CLEAR.
REQ-029 Sum SHALL wrap modulo 2^DOUT_WIDTH; no saturation.

Reset
REQ-030 rst_n=0 SHALL force IDLE, counter 0, m_valid_o=0, m_sum_o=0, m_ovf_o=0, s_ready_o=0, acc_enable_o=0, acc_data_o=0, busy_o=0.
REQ-031 acc_clear_o SHALL be 1 while rst_n=0, zeroing the accumulator; mid-frame reset SHALL discard the frame with no m_valid_o.

Configuration
REQ-032 Macro ACCUM_FRAME_CTRL_OVF_EN defined: REQ-028 logic built; undefined: m_ovf_o tied 0, no overflow logic.

Structure
REQ-033 Package accum_pkg SHALL hold FSM state enum typedef and default width constants.
REQ-034 Overflow detection SHALL be sub-module accum_ovf_chk, instantiated only under ACCUM_FRAME_CTRL_OVF_EN.

Verification
REQ-035 len=4, data 1,2,3,4 back-to-back, m_ready_i=1 -> one acc_clear_o pulse, m_sum_o=10, m_ovf_o=0, m_valid_o 7 cycles after start.
REQ-036 len=3, data -5,2,-1 with 2-cycle valid gaps -> acc_enable_o only on 3 handshakes, m_sum_o=0xFFFFFFFC.
REQ-037 len=2, data 0x7FFFFFFF,1 -> m_sum_o=0x80000000, m_ovf_o=1 with macro, 0 without.
REQ-038 m_ready_i low 5 cycles in OUT -> m_valid_o held, m_sum_o stable, s_ready_o=0, start_i ignored.
REQ-039 rst_n low after 2 of 4 samples -> IDLE, no m_valid_o, acc_clear_o=1 during reset; next frame len=1 data 7 -> m_sum_o=7.
REQ-040 start_i with frame_len_i=0 -> stays IDLE, busy_o=0, no acc_clear_o pulse.
